// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage MIPS core. Owns the word-organised data memory and
// performs byte / half / word loads and stores with a configurable number of
// wait states. Every output is combinational from the current inputs and the
// FSM state; the downstream MEM/WB register captures them.
//
// Parameters
//   MEM_WORDS    number of 32-bit words; address bits above the index wrap
//   WAIT_STATES  extra cycles per memory access (0..7)
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   MemRead         load request
//   MemWrite        store request (wins when both requests are set)
//   MemSize         00 byte, 01 half, 10/11 word
//   MemUnsigned     1 = zero-extend loads, 0 = sign-extend loads
//   WB_control_in   {RegWrite, MemtoReg} from EX/MEM
//   AluResult       byte address and pass-through ALU result
//   WriteData       store data, byte/half taken from the low bits
//   Destenation     destination register number
//   WB_control      {RegWrite, MemtoReg} to MEM/WB, bubbled while stalling
//   ReadData        extended load data, valid only in the final access cycle
//   _AluResult      AluResult passed through
//   _Destenation    Destenation passed through
//   stall           freezes PC, IF/ID, ID/EX and EX/MEM
//   misaligned      alignment fault on the current access
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [1:0]  WB_control_in,
    input  logic [31:0] AluResult,
    input  logic [31:0] WriteData,
    input  logic [4:0]  Destenation,
    output logic [1:0]  WB_control,
    output logic [31:0] ReadData,
    output logic [31:0] _AluResult,
    output logic [4:0]  _Destenation,
    output logic        stall,
    output logic        misaligned
);

    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0] CNT_INIT  = ZERO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    logic [2:0]  cnt;

    logic [31:0] mem [MEM_WORDS];

    logic [IDX_W-1:0] idx;
    logic             is_byte;
    logic             is_half;
    logic             is_word;
    logic             req;
    logic             mis;
    logic             access;
    logic             final_cyc;
    logic             stall_c;
    logic [31:0]      word_rd;
    logic [7:0]       byte_rd;
    logic [15:0]      half_rd;
    logic [31:0]      load_val;
    logic [3:0]       be;
    logic [31:0]      wlanes;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
        return uns ? {24'd0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
        return uns ? {16'd0, h} : {{16{h[15]}}, h};
    endfunction

    // Out-of-range addresses wrap: only the index bits select the word.
    assign idx     = AluResult[IDX_W+1:2];
    assign is_byte = (MemSize == 2'b00);
    assign is_half = (MemSize == 2'b01);
    assign is_word = MemSize[1];

    // The fault only applies to memory instructions; ALU results that happen
    // to be odd must still write back.
    assign req    = MemRead | MemWrite;
    assign mis    = req & ((is_half & AluResult[0]) | (is_word & (AluResult[1:0] != 2'b00)));
    assign access = req & ~mis;

    // The final cycle is the one in which data is delivered and a store commits.
    assign final_cyc = (state == S_IDLE && access && ZERO_WAIT) ||
                       (state == S_WAIT && cnt == 3'd0);
    assign stall_c   = (state == S_IDLE && access && !ZERO_WAIT) ||
                       (state == S_WAIT && cnt != 3'd0);

    // Asynchronous array read and lane extraction.
    assign word_rd = mem[idx];
    assign byte_rd = word_rd[{AluResult[1:0], 3'b000} +: 8];
    assign half_rd = AluResult[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        if (is_byte)      load_val = ext_byte(byte_rd, MemUnsigned);
        else if (is_half) load_val = ext_half(half_rd, MemUnsigned);
        else              load_val = word_rd;
    end

    // Little-endian byte enables; store data replicated across lanes so each
    // enabled lane already holds the right bits.
    always_comb begin
        be     = 4'b0000;
        wlanes = WriteData;
        if (is_byte) begin
            be              = 4'b0001 << AluResult[1:0];
            wlanes          = {4{WriteData[7:0]}};
        end else if (is_half) begin
            be              = AluResult[1] ? 4'b1100 : 4'b0011;
            wlanes          = {2{WriteData[15:0]}};
        end else begin
            be              = 4'b1111;
        end
    end

    // Commit only at the edge ending the final cycle; a reset aborts it.
    always_ff @(posedge clk) begin
        if (!rst && final_cyc && MemWrite && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access && !ZERO_WAIT) begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 3'd0) cnt   <= cnt - 3'd1;
                    else             state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bubble while stalling so MEM/WB never writes the same instruction twice.
    always_comb begin
        WB_control = WB_control_in;
        if (rst || stall_c) WB_control = 2'b00;
        else if (mis)       WB_control[1] = 1'b0;
    end

    assign ReadData     = (!rst && final_cyc && MemRead && !MemWrite && !mis) ? load_val : 32'd0;
    assign stall        = !rst && stall_c;
    assign misaligned   = !rst && mis;
    assign _AluResult   = AluResult;
    assign _Destenation = Destenation;

endmodule
